// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decoder handshake
// and the branch/halt controls that steer fetch.
interface fetch_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, a small instruction FIFO
// toward the decoder, and redirect handling that flushes buffered and in-flight words.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [15:0] PC_STEP    = 16'h0001
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [15:0]      pc_q, pc_d;
    logic [15:0]      req_pc_q, req_pc_d;
    logic [47:0]      fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             req_q, req_d;
    logic [15:0]      addr_q, addr_d;
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [15:0]      ipc_q, ipc_d;

    logic             gnt_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_after_s;
    logic             can_issue_s;
    logic             can_reissue_s;
    logic [47:0]      head_s;

    // A redirect in the same cycle cancels both the push and the pop.
    assign gnt_s         = (state_q == REQ) && bus.imem_gnt;
    assign push_s        = (state_q == WAIT) && bus.imem_rvalid && !bus.redirect;
    assign pop_s         = valid_q && bus.instr_ready && !bus.redirect;
    assign count_after_s = count_q + CNT_W'(1) - CNT_W'(pop_s);
    assign can_issue_s   = !bus.halt && !bus.redirect && (count_q < DEPTH_C);
    assign can_reissue_s = !bus.halt && !bus.redirect && (count_after_s < DEPTH_C);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a redirect that coincides with rvalid leaves nothing in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (can_issue_s) state_d = REQ;
                else             state_d = IDLE;
            end
            REQ: begin
                if (bus.redirect)      state_d = bus.imem_gnt ? DROP : IDLE;
                else if (bus.imem_gnt) state_d = WAIT;
                else                   state_d = REQ;
            end
            WAIT: begin
                if (bus.imem_rvalid)   state_d = can_reissue_s ? REQ : IDLE;
                else if (bus.redirect) state_d = DROP;
                else                   state_d = WAIT;
            end
            DROP: begin
                if (bus.imem_rvalid) state_d = IDLE;
                else                 state_d = DROP;
            end
            default: state_d = IDLE;
        endcase
    end

    // PC and FIFO bookkeeping.
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            pc_d     = bus.redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (gnt_s) begin
                pc_d     = pc_q + PC_STEP;
                req_pc_d = pc_q;
            end else begin
                pc_d     = pc_q;
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // FSM outputs and decoder-facing head, computed one cycle ahead so they leave on flops.
    always_comb begin
        req_d  = (state_d == REQ);
        addr_d = pc_d;
        if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_s = {req_pc_q, bus.imem_rdata};
        end else begin
            head_s = fifo_q[rd_ptr_d];
        end
        valid_d = (count_d != '0);
        if (valid_d) begin
            instr_d = head_s[31:0];
            ipc_d   = head_s[47:32];
        end else begin
            instr_d = instr_q;
            ipc_d   = ipc_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= 48'h0;
            end
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            ipc_q    <= 16'h0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                fifo_q[wr_ptr_q] <= {req_pc_q, bus.imem_rdata};
            end
            req_q    <= req_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
endmodule
